// File: rtl/cube_scramble_if.sv
// Move/handshake bus for cube_scramble: move offers in, packed cube state and status out.
interface cube_scramble_if;
  logic         start;
  logic         mv_valid;
  logic [4:0]   mv;
  logic         mv_last;
  logic         mv_ready;
  logic [119:0] state;
  logic         busy;
  logic         done;
  logic         err;
  logic [5:0]   count;

  modport master (
    output start, mv_valid, mv, mv_last,
    input  mv_ready, state, busy, done, err, count
  );

  modport slave (
    input  start, mv_valid, mv, mv_last,
    output mv_ready, state, busy, done, err, count
  );
endinterface

// File: rtl/cube_scramble.sv
// cube_scramble: applies a stream of face-turn moves to a packed 3x3 cube state.
// Each accepted move is executed as 1..3 clockwise quarter-turn passes, one per cycle.
// Optional feature macro: CUBE_SCRAMBLE_LOAD_EN adds load/init_state to start from an
// arbitrary cube instead of the solved one.
module cube_scramble (
  input  logic          clk,
  input  logic          rst_n,
`ifdef CUBE_SCRAMBLE_LOAD_EN
  input  logic          load,
  input  logic [119:0]  init_state,
`endif
  cube_scramble_if.slave bus
);

  // eo | ep (11..0) | pad | co | pad | cp (7..0)
  localparam logic [119:0] SOLVED =
    {12'h000, 48'hBA98_7654_3210, 8'h00, 16'h0000, 12'h000, 24'o76543210};

  typedef enum logic [1:0] {IDLE, READY, APPLY, DONE} st_t;

  st_t          st_q, st_d;
  logic [119:0] cube_q, cube_nxt;
  logic [2:0]   face_q;
  logic [1:0]   pass_q;     // quarter-turn passes still to perform
  logic         last_q;
  logic [5:0]   count_q;
  logic         err_q;

  logic         code_ok, accept, do_start, do_load;
  logic [2:0]   mv_face;
  logic [1:0]   mv_turn;

  assign code_ok = (bus.mv < 5'd18);
  assign mv_face = 3'(bus.mv / 5'd3);
  assign mv_turn = 2'(bus.mv % 5'd3);
  assign accept  = (st_q == READY) && bus.mv_valid;
`ifdef CUBE_SCRAMBLE_LOAD_EN
  assign do_load = (st_q == IDLE) && load;
`else
  assign do_load = 1'b0;
`endif
  assign do_start = (st_q == IDLE) && bus.start && !do_load;

  // One clockwise quarter turn of face_q applied to the current cube.
  logic [11:0][3:0] ep, nep;
  logic [11:0]      eo, neo;
  logic [7:0][2:0]  cp, ncp;
  logic [7:0][1:0]  co, nco;
  logic [3:0][2:0]  cc;       // corner cycle, cc[k] moves to cc[k+1]
  logic [3:0][1:0]  ct;       // twist added on arrival at cc[k]
  logic [3:0][3:0]  ec;       // edge cycle
  logic             fl;       // edges flip on this face
  logic [2:0]       tsum;
  logic [1:0]       ks, kd;

  always_comb begin
    ep = cube_q[107:60];
    eo = cube_q[119:108];
    cp = cube_q[23:0];
    co = cube_q[51:36];
    nep = ep; neo = eo; ncp = cp; nco = co;
    cc = '0; ct = '0; ec = '0; fl = 1'b0;
    tsum = '0; ks = '0; kd = '0;
    case (face_q)
      3'd0: begin  // U
        cc = {3'd3, 3'd2, 3'd1, 3'd0};
        ec = {4'd3, 4'd2, 4'd1, 4'd0};
      end
      3'd1: begin  // R
        cc = {3'd4, 3'd7, 3'd3, 3'd0};
        ct = {2'd1, 2'd2, 2'd1, 2'd2};
        ec = {4'd8, 4'd4, 4'd11, 4'd0};
      end
      3'd2: begin  // F
        cc = {3'd1, 3'd5, 3'd4, 3'd0};
        ct = {2'd2, 2'd1, 2'd2, 2'd1};
        ec = {4'd9, 4'd5, 4'd8, 4'd1};
        fl = 1'b1;
      end
      3'd3: begin  // D
        cc = {3'd6, 3'd7, 3'd4, 3'd5};
        ec = {4'd6, 4'd7, 4'd4, 4'd5};
      end
      3'd4: begin  // L
        cc = {3'd2, 3'd6, 3'd5, 3'd1};
        ct = {2'd2, 2'd1, 2'd2, 2'd1};
        ec = {4'd10, 4'd6, 4'd9, 4'd2};
      end
      3'd5: begin  // B
        cc = {3'd3, 3'd7, 3'd6, 3'd2};
        ct = {2'd2, 2'd1, 2'd2, 2'd1};
        ec = {4'd11, 4'd7, 4'd10, 4'd3};
        fl = 1'b1;
      end
      default: ;   // all-zero cycle degenerates to a no-op
    endcase
    for (int k = 0; k < 4; k++) begin
      ks = 2'(k);
      kd = ks + 2'd1;
      ncp[cc[kd]] = cp[cc[ks]];
      tsum = 3'(co[cc[ks]]) + 3'(ct[kd]);
      nco[cc[kd]] = (tsum >= 3'd3) ? 2'(tsum - 3'd3) : tsum[1:0];
      nep[ec[kd]] = ep[ec[ks]];
      neo[ec[kd]] = eo[ec[ks]] ^ fl;
    end
    cube_nxt = {neo, nep, 8'h00, nco, 12'h000, ncp};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // FSM next state: invalid codes never enter APPLY.
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:  if (do_load || do_start) st_d = READY;
      READY: if (accept) begin
               if (code_ok)          st_d = APPLY;
               else if (bus.mv_last) st_d = DONE;
             end
      APPLY: if (pass_q == 2'd1) st_d = last_q ? DONE : READY;
      DONE:  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Cube, move latch, counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cube_q  <= SOLVED;
      face_q  <= '0;
      pass_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (do_load) begin
`ifdef CUBE_SCRAMBLE_LOAD_EN
      cube_q  <= init_state &
                 {12'hFFF, 48'hFFFF_FFFF_FFFF, 8'h00, 16'hFFFF, 12'h000, 24'hFF_FFFF};
`endif
      count_q <= '0;
    end else if (do_start) begin
      cube_q  <= SOLVED;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (code_ok) begin
        face_q <= mv_face;
        pass_q <= mv_turn + 2'd1;
        last_q <= bus.mv_last;
        if (count_q != 6'd63) count_q <= count_q + 6'd1;
      end else begin
        err_q <= 1'b1;
      end
    end else if (st_q == APPLY) begin
      cube_q <= cube_nxt;
      pass_q <= pass_q - 2'd1;
    end
  end

  assign bus.mv_ready = (st_q == READY);
  assign bus.busy     = (st_q == READY) || (st_q == APPLY);
  assign bus.done     = (st_q == DONE);
  assign bus.state    = cube_q;
  assign bus.err      = err_q;
  assign bus.count    = count_q;

endmodule

// File: doc/cube_scramble.md
CUBE_SCRAMBLE -- requirements
Module: cube_scramble

Interface
REQ-001 SHALL have parameter-free ports as listed; sizes are fixed.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  in IDLE: load solved state, clear count, enter READY.
REQ-005 mv_valid  input  1  move offered.
REQ-006 mv  input  5  move code = face*3+turn; faces U0 R1 F2 D3 L4 B5; turn 0=CW quarter, 1=half, 2=prime.
REQ-007 mv_last  input  1  qualifies the accepted move as final.
REQ-008 mv_ready  output  1  high only in READY.
REQ-009 state  output  120  packed cube state, same format consumed by the solver's d input.
REQ-010 busy  output  1  high in READY and APPLY.
REQ-011 done  output  1  one-cycle pulse on completion.
REQ-012 err  output  1  sticky invalid-code flag.
REQ-013 count  output  6  accepted valid moves, saturating at 63.

Function
REQ-014 state packing: [119:108] eo[j] at bit 108+j; [107:60] ep[j] at 60+4j; [59:52] zero; [51:36] co[i] at 36+2i; [35:24] zero; [23:0] cp[i] at 3i.
REQ-015 Solved: ep[j]=j, cp[i]=i, all eo/co 0; pad fields always zero.
REQ-016 FSM states IDLE, READY, APPLY, DONE; IDLE->READY on start; READY->APPLY on mv_valid&mv_ready with valid code; APPLY->READY after final pass, or ->DONE if mv_last latched; DONE->IDLE unconditionally after one cycle.
REQ-017 Accepted move performs exactly 1/2/3 CW quarter-turn passes for turn 0/1/2, one pass per cycle starting the cycle after acceptance; mv_ready low throughout.
REQ-018 Quarter-turn piece cycles (a>b: piece at a moves to b): U C0>1>2>3>0, E0>1>2>3>0; D C5>4>7>6>5, E5>4>7>6>5; R C0>3>7>4>0, E0>11>4>8>0; F C0>4>5>1>0, E1>8>5>9>1; L C1>5>6>2>1, E2>9>6>10>2; B C2>6>7>3>2, E3>10>7>11>3.
REQ-019 Corner twist added mod 3 at destination position after move: R 0:+2 3:+1 7:+2 4:+1; F 0:+1 1:+2 4:+2 5:+1; L 1:+1 2:+2 6:+1 5:+2; B 2:+1 3:+2 7:+1 6:+2; U/D none.
REQ-020 Edge flip (XOR 1) at destination positions: F 1,5,8,9; B 3,7,10,11; others none.
REQ-021 Code >=18 accepted in READY: err<=1, state and count unchanged, stays READY; if mv_last, goes to DONE.
REQ-022 done high exactly the DONE cycle; state held stable from DONE until next start.
REQ-023 start outside IDLE ignored; mv_valid outside READY ignored.

Reset
REQ-024 rst_n low asynchronously forces IDLE, state=solved, count=0, err=0, done=0, mv_ready=0, busy=0, including mid-APPLY; partial pass discarded.
REQ-025 err clears only on reset or start.

Configuration
REQ-026 Macro CUBE_SCRAMBLE_LOAD_EN defined: adds input load (1) and input init_state (120); load in IDLE copies init_state (pad fields forced zero) to state, clears count, enters READY, priority over start.
REQ-027 Macro undefined: ports absent, start-only behaviour.

Verification
REQ-028 start, U with mv_last -> after 1 apply cycle done pulses; ep[0..3]=3,0,1,2; cp[0..3]=3,0,1,2; count=1.
REQ-029 F quarter alone -> state[119:108]=12'h322; co[0],co[1],co[4],co[5]=1,2,2,1.
REQ-030 R then R' (codes 3,5) -> state equals solved; mv_ready low 1 then 3 cycles; count=2.
REQ-031 R x4 back-to-back with mv_valid held -> solved; code 18 -> err=1, state unchanged.
REQ-032 rst_n asserted during second pass of B2 -> immediate solved state, IDLE, all outputs zero.
